// File: rtl/line_scan_scheduler.sv
// Per-line enable/flag register file plus a round-robin scan scheduler that dwells on each
// enabled line for a programmable number of cycles and pulses a strobe at the end of each dwell.
module line_scan_scheduler #(
    parameter int NUM_LINES   = 8,
    parameter int DEFAULT_DIV = 1024,
    parameter int DIV_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [3:0]             cmd_line,
    input  logic [15:0]            cmd_data,
    output logic                   cmd_error,
    output logic [NUM_LINES*3-1:0] line_out,
    output logic [3:0]             scan_line,
    output logic                   scan_valid,
    output logic                   scan_strobe
);

    typedef enum logic [1:0] {IDLE, SEEK, DWELL, STROBE} state_t;

    state_t               state_reg, state_next;
    logic [NUM_LINES-1:0] enable_reg, enable_next;
    logic [1:0]           flags_reg [NUM_LINES];
    logic [1:0]           flags_next [NUM_LINES];
    logic [DIV_W-1:0]     div_reg, div_next;
    logic [DIV_W-1:0]     cnt_reg, cnt_next;
    logic [3:0]           ptr_reg, ptr_next;
    logic [3:0]           scan_line_reg, scan_line_next;
    logic                 cmd_error_reg, cmd_error_next;

    logic                 xfer;
    logic                 line_ok;
    logic [15:0]          en16;
    logic                 found;
    logic [3:0]           found_idx;
    logic                 unused_bits;

    assign xfer        = cmd_valid && cmd_ready;
    assign line_ok     = {1'b0, cmd_line} < 5'(NUM_LINES);
    assign unused_bits = ^cmd_data;

    // Command decode: register next values from the transfer in this cycle.
    always_comb begin
        enable_next    = enable_reg;
        flags_next     = flags_reg;
        div_next       = div_reg;
        cmd_error_next = 1'b0;
        if (xfer) begin
            case (cmd_op)
                2'd0: begin
                    if (line_ok) begin
                        for (int i = 0; i < NUM_LINES; i++) begin
                            if (i == int'(cmd_line)) flags_next[i] = cmd_data[1:0];
                        end
                    end else begin
                        cmd_error_next = 1'b1;
                    end
                end
                2'd1: begin
                    if (line_ok) begin
                        for (int i = 0; i < NUM_LINES; i++) begin
                            if (i == int'(cmd_line)) enable_next[i] = cmd_data[0];
                        end
                    end else begin
                        cmd_error_next = 1'b1;
                    end
                end
                2'd2: enable_next = cmd_data[NUM_LINES-1:0];
                default: div_next = (cmd_data[DIV_W-1:0] == '0) ? DIV_W'(1) : cmd_data[DIV_W-1:0];
            endcase
        end
    end

    // The scheduler looks at post-command enables so a same-cycle disable wins over a strobe.
    assign en16 = 16'(enable_next);

    // Round-robin search starting just after ptr, wrapping; ptr itself is tried last.
    always_comb begin
        found     = 1'b0;
        found_idx = ptr_reg;
        for (int k = 1; k <= NUM_LINES; k++) begin
            if (!found && en16[(int'(ptr_reg) + k) % NUM_LINES]) begin
                found     = 1'b1;
                found_idx = 4'((int'(ptr_reg) + k) % NUM_LINES);
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        ptr_next       = ptr_reg;
        scan_line_next = scan_line_reg;
        case (state_reg)
            IDLE: begin
                if (|enable_reg) state_next = SEEK;
            end
            SEEK: begin
                if (found) begin
                    state_next     = DWELL;
                    ptr_next       = found_idx;
                    scan_line_next = found_idx;
                    cnt_next       = div_reg - DIV_W'(1);
                end else begin
                    state_next = IDLE;
                end
            end
            DWELL: begin
                if (!en16[scan_line_reg]) begin
                    state_next = SEEK;
                end else if (cnt_reg == '0) begin
                    state_next = STROBE;
                end else begin
                    cnt_next = cnt_reg - DIV_W'(1);
                end
            end
            default: state_next = SEEK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            enable_reg    <= '0;
            div_reg       <= DIV_W'(DEFAULT_DIV);
            cnt_reg       <= '0;
            ptr_reg       <= 4'(NUM_LINES - 1);
            scan_line_reg <= '0;
            cmd_error_reg <= 1'b0;
            for (int i = 0; i < NUM_LINES; i++) flags_reg[i] <= 2'b00;
        end else begin
            state_reg     <= state_next;
            enable_reg    <= enable_next;
            div_reg       <= div_next;
            cnt_reg       <= cnt_next;
            ptr_reg       <= ptr_next;
            scan_line_reg <= scan_line_next;
            cmd_error_reg <= cmd_error_next;
            for (int i = 0; i < NUM_LINES; i++) flags_reg[i] <= flags_next[i];
        end
    end

    assign cmd_ready   = !reset && (state_reg != STROBE);
    assign cmd_error   = cmd_error_reg;
    assign scan_line   = scan_line_reg;
    assign scan_valid  = (state_reg == DWELL) || (state_reg == STROBE);
    assign scan_strobe = (state_reg == STROBE);

    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line_out
            assign line_out[gi]                  = enable_reg[gi];
            assign line_out[NUM_LINES+2*gi +: 2] = flags_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_line_scan_scheduler.sv
// Directed bench for line_scan_scheduler: command handshake, error pulse, scan order, dwell timing,
// disable-during-dwell and reset-during-dwell.
module tb_line_scan_scheduler;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           cmd_valid = 1'b0;
    logic [1:0]     cmd_op = 2'd0;
    logic [3:0]     cmd_line = 4'd0;
    logic [15:0]    cmd_data = 16'd0;
    logic           cmd_ready;
    logic           cmd_error;
    logic [3*N-1:0] line_out;
    logic [3:0]     scan_line;
    logic           scan_valid;
    logic           scan_strobe;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    line_scan_scheduler #(
        .NUM_LINES  (N),
        .DEFAULT_DIV(1024),
        .DIV_W      (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_line   (cmd_line),
        .cmd_data   (cmd_data),
        .cmd_error  (cmd_error),
        .line_out   (line_out),
        .scan_line  (scan_line),
        .scan_valid (scan_valid),
        .scan_strobe(scan_strobe)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] line, input logic [15:0] data);
        int guard;
        guard     = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_line  = line;
        cmd_data  = data;
        while (!cmd_ready && guard < 10) begin
            step();
            guard++;
        end
        check("send_ready", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        $display("[TB] cmd op=%0d line=%0d data=0x%0h -> error=%0b line_out=0x%0h",
                 op, line, data, cmd_error, line_out);
    endtask

    task automatic wait_strobe(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!scan_strobe && n < 60);
        if (!scan_strobe) n = -1;
        $display("[TB] strobe after %0d cycles, scan_line=%0d", n, scan_line);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int strobes;
        int valids;

        // Reset values while reset is held
        step();
        step();
        check("rst_line_out", 32'(line_out), 32'h0);
        check("rst_scan_valid", 32'(scan_valid), 32'd0);
        check("rst_scan_strobe", 32'(scan_strobe), 32'd0);
        check("rst_cmd_error", 32'(cmd_error), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_scan_line", 32'(scan_line), 32'd0);
        reset = 1'b0;
        step();

        // div=4, lines 0 and 2 enabled: strobes alternate 0,2,0 every 6 cycles
        send(2'd3, 4'd0, 16'd4);
        send(2'd2, 4'd0, 16'h0005);
        check("mask_line_out", 32'(line_out), 32'h5);
        wait_strobe(n);
        check("strobe1_period", n, 6);
        check("strobe1_line", 32'(scan_line), 32'd0);
        check("strobe_ready_low", 32'(cmd_ready), 32'd0);
        wait_strobe(n);
        check("strobe2_period", n, 6);
        check("strobe2_line", 32'(scan_line), 32'd2);
        wait_strobe(n);
        check("strobe3_period", n, 6);
        check("strobe3_line", 32'(scan_line), 32'd0);

        // Flags write on line 3
        send(2'd0, 4'd3, 16'h0002);
        check("flags3_line_out", 32'(line_out), 32'h008005);

        // Out-of-range line: error pulse, no change, next command still accepted
        send(2'd1, 4'd9, 16'h0001);
        check("err_pulse", 32'(cmd_error), 32'd1);
        check("err_line_out", 32'(line_out), 32'h008005);
        step();
        check("err_clear", 32'(cmd_error), 32'd0);
        send(2'd0, 4'd0, 16'h0003);
        check("after_err_line_out", 32'(line_out), 32'h008305);
        check("after_err_noerr", 32'(cmd_error), 32'd0);

        // Reset asserted during a dwell
        n = 0;
        while (!(scan_valid && !scan_strobe) && n < 20) begin
            step();
            n++;
        end
        check("in_dwell", 32'(scan_valid), 32'd1);
        reset = 1'b1;
        step();
        check("mid_rst_line_out", 32'(line_out), 32'h0);
        check("mid_rst_scan_valid", 32'(scan_valid), 32'd0);
        check("mid_rst_scan_strobe", 32'(scan_strobe), 32'd0);
        check("mid_rst_scan_line", 32'(scan_line), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("mid_rst_cmd_error", 32'(cmd_error), 32'd0);
        reset = 1'b0;
        strobes = 0;
        valids  = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (scan_strobe) strobes++;
            if (scan_valid) valids++;
        end
        check("post_rst_strobes", strobes, 0);
        check("post_rst_valids", valids, 0);

        // Only line 2, div=8; disable it when cnt==3
        send(2'd3, 4'd0, 16'd8);
        send(2'd2, 4'd0, 16'h0004);
        step();
        step();
        check("l2_dwell_valid", 32'(scan_valid), 32'd1);
        check("l2_dwell_line", 32'(scan_line), 32'd2);
        for (int i = 0; i < 4; i++) step();
        send(2'd1, 4'd2, 16'h0000);
        check("l2_off_line_out", 32'(line_out), 32'h0);
        strobes = 0;
        valids  = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (scan_strobe) strobes++;
            if (scan_valid) valids++;
        end
        check("l2_off_strobes", strobes, 0);
        check("l2_off_valids", valids, 0);
        check("l2_off_idle_valid", 32'(scan_valid), 32'd0);

        // div=0 stores 1; line 7 alone strobes every 3 cycles
        send(2'd3, 4'd0, 16'd0);
        send(2'd1, 4'd7, 16'h0001);
        check("l7_line_out", 32'(line_out), 32'h80);
        for (int i = 0; i < 3; i++) begin
            wait_strobe(n);
            check("l7_period", n, 3);
            check("l7_line", 32'(scan_line), 32'd7);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
